// File: rtl/seq_detect_param_if.sv
// Bundle of the serial stream, configuration and result signals of seq_detect_param.
// The master drives the stream and configuration; the slave (the detector) returns found/match_count.
interface seq_detect_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             ser_in;
    logic             in_valid;
    logic [PAT_W-1:0] pattern;
    logic [PAT_W-1:0] mask;
    logic             p_load;
    logic             overlap;
    logic             o_load;
    logic             count_clr;
    logic             found;
    logic [CNT_W-1:0] match_count;

    modport master (
        output ser_in, in_valid, pattern, mask, p_load, overlap, o_load, count_clr,
        input  found, match_count
    );

    modport slave (
        input  ser_in, in_valid, pattern, mask, p_load, overlap, o_load, count_clr,
        output found, match_count
    );
endinterface

// File: rtl/seq_detect_param.sv
// PAT_W-bit serial pattern detector with overlap mode and a saturating match counter.
// Define SEQ_DETECT_MASK_EN to make the per-bit don't-care mask loadable; otherwise every bit is compared.
module seq_detect_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input logic               clock,
    input logic               rst,
    seq_detect_param_if.slave bus
);
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  window;
    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-1:0]  mask_q;
    logic [FILL_W-1:0] fill;
    logic              ovl_q;

    logic              accept_p0;
    logic              hit_p0;
    logic [PAT_W-1:0]  window_p0;
    logic [FILL_W-1:0] fill_p0;

    logic              found_p1;
    logic [CNT_W-1:0]  count_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Stage p0: candidate history after accepting this edge's bit, and the hit decision.
    always_comb begin
        accept_p0 = bus.in_valid && !bus.p_load;
        window_p0 = {window[PAT_W-2:0], bus.ser_in};
        fill_p0   = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
        hit_p0    = accept_p0 && (fill_p0 == FILL_FULL)
                    && (((window_p0 ^ pat_q) & mask_q) == '0);
    end

`ifdef SEQ_DETECT_MASK_EN
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            mask_q <= '1;
        end else if (bus.p_load) begin
            mask_q <= bus.mask;
        end
    end
`else
    logic unused_mask;
    assign mask_q      = '1;
    assign unused_mask = ^bus.mask;
`endif

    // Non-overlap restarts the history on a hit; ovl_q here is still the pre-o_load mode.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            pat_q  <= '0;
            ovl_q  <= 1'b0;
            window <= '0;
            fill   <= '0;
        end else begin
            if (bus.p_load) begin
                pat_q  <= bus.pattern;
                window <= '0;
                fill   <= '0;
            end else if (accept_p0) begin
                window <= window_p0;
                fill   <= (hit_p0 && !ovl_q) ? '0 : fill_p0;
            end
            if (bus.o_load) begin
                ovl_q <= bus.overlap;
            end
        end
    end

    // Stage p1: registered match pulse and counter, both updated on the hit edge.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            found_p1 <= 1'b0;
            count_p1 <= '0;
        end else begin
            found_p1 <= hit_p0;
            if (bus.count_clr) begin
                count_p1 <= hit_p0 ? CNT_W'(1) : '0;
            end else if (hit_p0) begin
                count_p1 <= sat_inc(count_p1);
            end
        end
    end

    assign bus.found       = found_p1;
    assign bus.match_count = count_p1;
endmodule
